cpu_io_bridge: RTL and testbench
================================

Name: cpu_io_bridge

Overview:
- Host-side responder for the general processor's 8-bit Input/Output ports.
- Input channel: holds one host-supplied byte and presents it on the processor's Input bus. The byte is consumed when the processor executes an IN instruction.
- Output channel: captures each processor OUT write into a small FIFO. The host drains the FIFO with a valid/ready handshake.
- Instantiated beside general_processor at the top level; wired between the processor and board switches/LEDs or a UART.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, 2..16.
- AW, 2, FIFO pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- host_in_data  input  8  byte offered by the host to the processor.
- host_in_valid  input  1  host_in_data is valid.
- host_in_ready  output  1  input holding register can accept a byte.
- cpu_input  output  8  drives the processor Input bus.
- cpu_in_rd  input  1  processor consumes Input this cycle (INmux & Aload).
- cpu_output  input  8  processor Output bus.
- cpu_out_we  input  1  processor OutE level.
- host_out_data  output  8  FIFO head byte.
- host_out_valid  output  1  FIFO not empty.
- host_out_ready  input  1  host accepts host_out_data.
- in_underflow  output  1  sticky: processor read with no fresh byte.
- out_overflow  output  1  sticky: processor write dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-high): all outputs and registers clear. The values are cpu_input=0, host_in_ready=1, host_out_valid=0, host_out_data=0, in_underflow=0, out_overflow=0, FIFO pointers=0, count=0, input FSM=EMPTY.
- Reset asserted mid-transfer discards the held input byte and all FIFO contents immediately, with no clock required.
- Input FSM has two states, EMPTY and FULL.
  - EMPTY: host_in_ready=1. If host_in_valid=1, latch host_in_data into cpu_input on this edge and go to FULL.
  - FULL: host_in_ready=0. If cpu_in_rd=1, go to EMPTY; cpu_input keeps its value.
- cpu_input is registered and changes only on a host accept. The processor therefore sees the last accepted byte even after consumption.
- cpu_in_rd in EMPTY sets in_underflow; the processor reads the stale cpu_input.
- cpu_in_rd and host_in_valid in the same cycle:
  - In FULL, the state goes to EMPTY and the new byte is not accepted, because ready was 0.
  - In EMPTY, the byte is accepted and the state goes to FULL. The concurrent cpu_in_rd still counts as underflow.
- Output capture: a push occurs on the rising edge of cpu_out_we. An internal delayed copy detects 0->1. This gives one push per OUT instruction even if OutE is held high for several cycles. The byte pushed is cpu_output sampled in that cycle.
- FIFO behaviour:
  - Circular buffer; AW-bit write and read pointers wrap from DEPTH-1 to 0.
  - count is AW+1 bits.
  - host_out_valid=(count!=0).
  - host_out_data shows the head entry combinationally from storage.
  - A pop occurs when host_out_valid & host_out_ready.
- Push and pop in the same cycle with count>0: both are performed and count is unchanged. This includes the full case: a pop at full frees a slot and the push succeeds.
- Push with count=DEPTH and no pop: the byte is dropped, out_overflow is set, and the pointers are unchanged.
- Push with count=0 and host_out_ready=1: the byte becomes valid on the next cycle. Latency from OutE rising to host_out_valid is 1 clk.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: CPU_IO_BRIDGE_DEDUP_EN.
- Defined: an output push is suppressed when cpu_output equals the last byte actually pushed. A suppressed push does not touch the FIFO and never sets out_overflow.
  - A last-pushed register holds this byte and a flag marks it valid; both clear on reset.
  - The first push after reset always occurs.
- Undefined: every OutE rising edge pushes, and duplicate bytes are stored.

Test Plan:
- Reset released, host offers 0x5A with host_in_valid=1 -> next cycle cpu_input=0x5A and host_in_ready=0. A cpu_in_rd pulse then gives host_in_ready=1, cpu_input still 0x5A, in_underflow=0.
- cpu_in_rd pulse while EMPTY -> in_underflow=1 and stays 1 until reset.
- OutE high for 3 cycles with cpu_output=0x11, host_out_ready=0 -> exactly one entry; host_out_valid=1 one cycle after the rising edge; host_out_data=0x11.
- Five OUT pulses 0x01..0x05, DEPTH=4, host_out_ready=0 -> FIFO holds 0x01..0x04 and out_overflow=1. Draining gives 0x01,0x02,0x03,0x04 in order, then host_out_valid=0.
- FIFO full plus a simultaneous push 0x09 and pop -> pop returns the head, 0x09 is stored, count stays 4, out_overflow unchanged.
- With CPU_IO_BRIDGE_DEDUP_EN, OUT 0x22, 0x22, 0x23 -> FIFO receives 0x22, 0x23 only. Without the macro -> 0x22, 0x22, 0x23.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// Host-side responder for the processor's 8-bit IN/OUT ports: one-byte input holding register plus output FIFO.
// Optional macro CPU_IO_BRIDGE_DEDUP_EN suppresses output pushes that repeat the last pushed byte.
module cpu_io_bridge #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] host_in_data,
   input  logic       host_in_valid,
   output logic       host_in_ready,
   output logic [7:0] cpu_input,
   input  logic       cpu_in_rd,
   input  logic [7:0] cpu_output,
   input  logic       cpu_out_we,
   output logic [7:0] host_out_data,
   output logic       host_out_valid,
   input  logic       host_out_ready,
   output logic       in_underflow,
   output logic       out_overflow
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [0:0]    state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          we_d;
   logic          push_req;
   logic          dup;
   logic          push;
   logic          pop;
   logic          full;
   logic          do_push;

   // ---------------- input channel ----------------
   assign host_in_ready = (state == ST_EMPTY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_EMPTY;
         cpu_input    <= '0;
         in_underflow <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (cpu_in_rd)
                  in_underflow <= 1'b1;
               if (host_in_valid) begin
                  cpu_input <= host_in_data;
                  state     <= ST_FULL;
               end
            end
            default: begin
               if (cpu_in_rd)
                  state <= ST_EMPTY;
            end
         endcase
      end
   end

   // ---------------- output channel ----------------
   // One push per OUT instruction: only the 0->1 edge of OutE counts.
   assign push_req = cpu_out_we & ~we_d;

`ifdef CPU_IO_BRIDGE_DEDUP_EN
   logic [7:0] last_pushed;
   logic       last_valid;

   assign dup = last_valid && (last_pushed == cpu_output);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_pushed <= '0;
         last_valid  <= 1'b0;
      end else if (do_push) begin
         last_pushed <= cpu_output;
         last_valid  <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign push           = push_req & ~dup;
   assign host_out_valid = (count != '0);
   assign host_out_data  = mem[rd_ptr];
   assign pop            = host_out_valid & host_out_ready;
   assign full           = (count == FULL_COUNT);
   // A pop at full frees the slot the concurrent push needs.
   assign do_push        = push & (~full | pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         we_d         <= 1'b0;
         out_overflow <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         we_d <= cpu_out_we;
         if (do_push) begin
            mem[wr_ptr] <= cpu_output;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)
            count <= count + 1'b1;
         else if (!do_push && pop)
            count <= count - 1'b1;
         if (push && !do_push)
            out_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Self-checking bench for cpu_io_bridge: directed scenarios followed by a randomized run against a queue-based model.
module tb_cpu_io_bridge;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] host_in_data;
   logic       host_in_valid;
   logic       host_in_ready;
   logic [7:0] cpu_input;
   logic       cpu_in_rd;
   logic [7:0] cpu_output;
   logic       cpu_out_we;
   logic [7:0] host_out_data;
   logic       host_out_valid;
   logic       host_out_ready;
   logic       in_underflow;
   logic       out_overflow;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   cpu_io_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .host_in_data   (host_in_data),
      .host_in_valid  (host_in_valid),
      .host_in_ready  (host_in_ready),
      .cpu_input      (cpu_input),
      .cpu_in_rd      (cpu_in_rd),
      .cpu_output     (cpu_output),
      .cpu_out_we     (cpu_out_we),
      .host_out_data  (host_out_data),
      .host_out_valid (host_out_valid),
      .host_out_ready (host_out_ready),
      .in_underflow   (in_underflow),
      .out_overflow   (out_overflow)
   );

   task automatic check_b(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check_v(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      host_in_data   = '0;
      host_in_valid  = 1'b0;
      cpu_in_rd      = 1'b0;
      cpu_output     = '0;
      cpu_out_we     = 1'b0;
      host_out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic out_pulse(input logic [7:0] b);
      cpu_output = b;
      cpu_out_we = 1'b1;
      step();
      cpu_out_we = 1'b0;
      step();
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] b);
      check_b({tag, "_valid"}, host_out_valid, 1'b1);
      check_v({tag, "_data"}, host_out_data, b);
      host_out_ready = 1'b1;
      step();
      host_out_ready = 1'b0;
   endtask

   // reference model state
   logic       m_in_full;
   logic [7:0] m_in_byte;
   logic       m_unf;
   logic       m_ovf;
   logic       m_prev_we;
   logic [7:0] m_last;
   logic       m_last_v;
   logic [7:0] m_q [$];

   initial begin
      logic [7:0] d8;
      logic       fifo_was_full;
      logic       m_pop;
      logic       dedup_hit;

      idle_inputs();
      reset = 1'b1;
      #2;
      check_v("rst_cpu_input", cpu_input, 8'h00);
      check_b("rst_in_ready", host_in_ready, 1'b1);
      check_b("rst_out_valid", host_out_valid, 1'b0);
      check_v("rst_out_data", host_out_data, 8'h00);
      check_b("rst_underflow", in_underflow, 1'b0);
      check_b("rst_overflow", out_overflow, 1'b0);
      step();
      reset = 1'b0;

      // input handshake
      host_in_data = 8'h5A; host_in_valid = 1'b1;
      step();
      host_in_valid = 1'b0;
      check_v("in_latch", cpu_input, 8'h5A);
      check_b("in_ready_full", host_in_ready, 1'b0);
      cpu_in_rd = 1'b1;
      step();
      cpu_in_rd = 1'b0;
      check_b("in_ready_after_rd", host_in_ready, 1'b1);
      check_v("in_hold_after_rd", cpu_input, 8'h5A);
      check_b("in_no_underflow", in_underflow, 1'b0);

      // underflow is sticky
      cpu_in_rd = 1'b1;
      step();
      cpu_in_rd = 1'b0;
      check_b("underflow_set", in_underflow, 1'b1);
      step(); step();
      check_b("underflow_sticky", in_underflow, 1'b1);

      // OutE held high for 3 cycles yields one entry
      cpu_output = 8'h11; cpu_out_we = 1'b1;
      step();
      check_b("oute_latency_valid", host_out_valid, 1'b1);
      check_v("oute_data", host_out_data, 8'h11);
      step(); step();
      cpu_out_we = 1'b0;
      step();
      pop_expect("oute_single", 8'h11);
      check_b("oute_one_entry", host_out_valid, 1'b0);

      // overflow with five pushes into a 4-deep FIFO
      for (int i = 1; i <= 5; i++) out_pulse(8'(i));
      check_b("ovf_set", out_overflow, 1'b1);
      for (int i = 1; i <= 4; i++) pop_expect("ovf_drain", 8'(i));
      check_b("ovf_empty", host_out_valid, 1'b0);

      // push and pop together while full
      do_reset();
      for (int i = 1; i <= 4; i++) out_pulse(8'(i));
      check_v("full_head", host_out_data, 8'h01);
      cpu_output = 8'h09; cpu_out_we = 1'b1; host_out_ready = 1'b1;
      step();
      cpu_out_we = 1'b0; host_out_ready = 1'b0;
      check_b("full_pp_no_ovf", out_overflow, 1'b0);
      step();
      pop_expect("full_pp_drain", 8'h02);
      pop_expect("full_pp_drain", 8'h03);
      pop_expect("full_pp_drain", 8'h04);
      pop_expect("full_pp_drain", 8'h09);
      check_b("full_pp_empty", host_out_valid, 1'b0);

      // duplicate bytes
      do_reset();
      out_pulse(8'h22); out_pulse(8'h22); out_pulse(8'h23);
      pop_expect("dup_first", 8'h22);
`ifndef CPU_IO_BRIDGE_DEDUP_EN
      pop_expect("dup_second", 8'h22);
`endif
      pop_expect("dup_last", 8'h23);
      check_b("dup_empty", host_out_valid, 1'b0);

      // simultaneous read and offer
      do_reset();
      host_in_data = 8'hA1; host_in_valid = 1'b1; cpu_in_rd = 1'b1;
      step();
      check_v("sim_empty_accept", cpu_input, 8'hA1);
      check_b("sim_empty_unf", in_underflow, 1'b1);
      check_b("sim_empty_full", host_in_ready, 1'b0);
      host_in_data = 8'hB2;
      step();
      host_in_valid = 1'b0; cpu_in_rd = 1'b0;
      check_v("sim_full_reject", cpu_input, 8'hA1);
      check_b("sim_full_empty", host_in_ready, 1'b1);

      // asynchronous reset mid-transfer
      host_in_data = 8'h77; host_in_valid = 1'b1;
      out_pulse(8'h33);
      host_in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_v("areset_cpu_input", cpu_input, 8'h00);
      check_b("areset_in_ready", host_in_ready, 1'b1);
      check_b("areset_out_valid", host_out_valid, 1'b0);
      check_b("areset_unf", in_underflow, 1'b0);
      step();
      reset = 1'b0;

      // randomized run against the model
      m_in_full = 1'b0; m_in_byte = '0; m_unf = 1'b0; m_ovf = 1'b0;
      m_prev_we = 1'b0; m_last = '0; m_last_v = 1'b0;
      m_q.delete();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         host_in_data   = 8'($urandom);
         host_in_valid  = ($urandom_range(0, 9) < 4);
         cpu_in_rd      = ($urandom_range(0, 9) < 3);
         cpu_output     = 8'($urandom_range(0, 3));
         cpu_out_we     = ($urandom_range(0, 9) < 5);
         host_out_ready = ($urandom_range(0, 9) < 3);

         if (!m_in_full) begin
            if (cpu_in_rd) m_unf = 1'b1;
            if (host_in_valid) begin
               m_in_byte = host_in_data;
               m_in_full = 1'b1;
            end
         end else if (cpu_in_rd) begin
            m_in_full = 1'b0;
         end

         fifo_was_full = (m_q.size() == DEPTH);
         m_pop = (m_q.size() != 0) && host_out_ready;
         if (m_pop) d8 = m_q.pop_front();
`ifdef CPU_IO_BRIDGE_DEDUP_EN
         dedup_hit = m_last_v && (m_last == cpu_output);
`else
         dedup_hit = 1'b0;
`endif
         if (cpu_out_we && !m_prev_we && !dedup_hit) begin
            if (fifo_was_full && !m_pop) m_ovf = 1'b1;
            else begin
               m_q.push_back(cpu_output);
               m_last   = cpu_output;
               m_last_v = 1'b1;
            end
         end
         m_prev_we = cpu_out_we;

         step();
         check_v("rnd_cpu_input", cpu_input, m_in_byte);
         check_b("rnd_in_ready", host_in_ready, !m_in_full);
         check_b("rnd_out_valid", host_out_valid, m_q.size() != 0);
         if (m_q.size() != 0) check_v("rnd_out_data", host_out_data, m_q[0]);
         check_b("rnd_underflow", in_underflow, m_unf);
         check_b("rnd_overflow", out_overflow, m_ovf);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
